// File: rtl/gf16_pkg.sv
// Shared definitions for the GF(2^16) divider: field constants, FSM state
// encoding and a bit-exact software multiply for benches.
package gf16_pkg;

    localparam int          GF_M    = 16;
    localparam logic [15:0] GF_POLY = 16'h002D;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        MULB = 3'd2,
        FSQR = 3'd3,
        MULA = 3'd4
    } state_t;

    // Carry-less product followed by top-down reduction. Each set bit k >= 16
    // folds back onto k-11, k-13, k-14 and k-16.
    function automatic logic [15:0] gf16_mul_f(input logic [15:0] a, input logic [15:0] b);
        logic [30:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                p = p ^ ({15'b0, a} << i);
            end
        end
        for (int k = 30; k >= 16; k--) begin
            if (p[k]) begin
                p[k]      = 1'b0;
                p[k - 11] = ~p[k - 11];
                p[k - 13] = ~p[k - 13];
                p[k - 14] = ~p[k - 14];
                p[k - 16] = ~p[k - 16];
            end
        end
        return p[15:0];
    endfunction

endpackage

// File: rtl/gf16_mul_comb.sv
// Combinational GF(2^16) multiplier over x^16 + x^5 + x^3 + x^2 + 1.
module gf16_mul_comb
    import gf16_pkg::*;
(
    input  logic [GF_M-1:0] i_x,
    input  logic [GF_M-1:0] i_y,
    output logic [GF_M-1:0] o_p
);

    // Shift-and-XOR partial products, then fold the high bits down one at a
    // time from the top so that folds landing at >= 16 are caught later.
    always_comb begin : p_mul
        logic [30:0] v_acc;
        v_acc = '0;
        for (int i = 0; i < GF_M; i++) begin
            if (i_y[i]) begin
                v_acc = v_acc ^ ({15'b0, i_x} << i);
            end
        end
        for (int k = 30; k >= GF_M; k--) begin
            if (v_acc[k]) begin
                v_acc[k]             = 1'b0;
                v_acc[k - GF_M +: 16] = v_acc[k - GF_M +: 16] ^ GF_POLY;
            end
        end
        o_p = v_acc[GF_M-1:0];
    end

endmodule

// File: rtl/gf16_divider.sv
// Sequential GF(2^16) divider: Q = A * B^(2^16-2), one multiply per clock,
// fixed 30-cycle latency. B == 0 yields Q = 0 with div_by_zero flagged.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SQR   | r <= r*r (first half of a square-and-multiply round)
// MULB  | r <= r*b, round count advances; 14 rounds build B^(2^15-1)
// FSQR  | final square, r becomes B^(2^16-2) = B^-1
// MULA  | quotient <= r*a, pulse done
module gf16_divider
    import gf16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [GF_M-1:0] din_a,
    input  logic [GF_M-1:0] din_b,
    output logic            busy,
    output logic            done,
    output logic [GF_M-1:0] quotient,
    output logic            div_by_zero
);

    state_t          r_state;
    logic [GF_M-1:0] r_a;
    logic [GF_M-1:0] r_b;
    logic [GF_M-1:0] r_r;
    logic [3:0]      r_rnd;
    logic            r_busy;
    logic            r_done;
    logic [GF_M-1:0] r_quot;
    logic            r_dbz;

    logic [GF_M-1:0] w_op_y;
    logic [GF_M-1:0] w_prod;

    // Second multiplier operand: r for squaring, b or a for the multiply steps.
    always_comb begin
        w_op_y = r_r;
        case (r_state)
            MULB:    w_op_y = r_b;
            MULA:    w_op_y = r_a;
            default: w_op_y = r_r;
        endcase
    end

    gf16_mul_comb u_mul (
        .i_x (r_r),
        .i_y (w_op_y),
        .o_p (w_prod)
    );

    // Control FSM, operand registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= din_a;
                        r_b     <= din_b;
                        r_r     <= din_b;
                        r_rnd   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SQR;
                    end
                end
                SQR: begin
                    r_r     <= w_prod;
                    r_state <= MULB;
                end
                MULB: begin
                    r_r     <= w_prod;
                    r_rnd   <= r_rnd + 4'd1;
                    r_state <= (r_rnd == 4'd13) ? FSQR : SQR;
                end
                FSQR: begin
                    r_r     <= w_prod;
                    r_state <= MULA;
                end
                MULA: begin
                    r_quot  <= w_prod;
                    r_dbz   <= (r_b == '0);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf16_divider.sv
// Scoreboard bench for gf16_divider: the driver pushes expectations on each
// accepted start, an independent monitor pops and checks on each done pulse.
module tb_gf16_divider;
    import gf16_pkg::*;

    localparam int NRAND = 1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din_a;
    logic [15:0] din_b;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic        div_by_zero;

    gf16_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .din_a       (din_a),
        .din_b       (din_b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        bit          has_q;
        bit          dbz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    bit   spacing_on = 0;
    bit   have_last  = 0;
    int   last_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent Horner-style multiply: shift by x, reduce with 0x002D.
    function automatic logic [15:0] tb_mul(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] acc;
        acc = '0;
        for (int i = 15; i >= 0; i--) begin
            acc = {acc[14:0], 1'b0} ^ (acc[15] ? 16'h002D : 16'h0000);
            if (y[i]) acc = acc ^ x;
        end
        return acc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                if (e.has_q) chk("quotient", quotient, e.q);
                else         chk("inverse_check", tb_mul(quotient, e.b), e.a);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("latency", cyc - e.acc, 30);
            end
            if (spacing_on) begin
                if (have_last) chk("done_spacing", cyc - last_done, 31);
                last_done = cyc;
                have_last = 1;
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input bit dbz, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        din_a = a;
        din_b = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.a = a; e.b = b; e.q = q; e.has_q = 1; e.dbz = dbz; e.acc = cyc;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        int cnt0;
        exp_t e;

        rst_n = 1'b0;
        start = 1'b0;
        din_a = '0;
        din_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        chk("pkg_mul_x_inv", gf16_mul_f(16'h8016, 16'h0002), 16'h0001);

        issue(16'h0001, 16'h0001, 16'h0001, 0, 1); wait_idle();
        issue(16'h0001, 16'h0002, 16'h8016, 0, 1); wait_idle();
        issue(16'h1234, 16'h0001, 16'h1234, 0, 1); wait_idle();
        issue(16'h0000, 16'h0005, 16'h0000, 0, 1); wait_idle();
        issue(16'hBEEF, 16'h0000, 16'h0000, 1, 1); wait_idle();
        issue(16'h8016, 16'h8016, 16'h0001, 0, 1); wait_idle();
        issue(16'h0001, 16'h8016, 16'h0002, 0, 1); wait_idle();

        // Reset 12 clocks into an operation: no done may follow.
        cnt0 = done_cnt;
        issue(16'h1234, 16'h0003, 16'h0000, 0, 0);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("midrst_no_done", done_cnt, cnt0);
        chk("midrst_idle_busy", busy, 0);

        // Start while busy is ignored.
        cnt0 = done_cnt;
        issue(16'h00AB, 16'h0001, 16'h00AB, 0, 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        din_a = 16'hFFFF;
        din_b = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        #1;
        chk("busy_start_one_done", done_cnt - cnt0, 1);

        // Back-to-back random traffic with start held high.
        spacing_on = 1;
        have_last  = 0;
        n = 0;
        guard = 0;
        while (n < NRAND && guard < NRAND * 40) begin
            @(negedge clk);
            guard++;
            if (!busy) begin
                start = 1'b1;
                din_a = 16'($urandom_range(0, 65535));
                din_b = 16'($urandom_range(1, 65535));
                @(posedge clk);
                #1;
                e.a = din_a; e.b = din_b; e.q = '0; e.has_q = 0; e.dbz = 0; e.acc = cyc;
                sb.push_back(e);
                n++;
            end
        end
        start = 1'b0;
        chk("random_issued", n, NRAND);
        wait_idle();
        spacing_on = 0;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
